// File: rtl/multi_port_ram.sv
// -----------------------------------------------------------------------------
// multi_port_ram
// Instruction/data RAM for the RISC-V core, organised as DEPTH 32-bit words.
// After every reset a sequencer zero-fills the array. Requests are accepted
// only while `ready` is high.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   ready          high once the zero-fill has finished; requests accepted
//   if_req         fetch request
//   if_addr        fetch byte address (bits [1:0] ignored)
//   if_rdata       fetched word; holds its value between fetches
//   if_valid       one-cycle pulse, if_rdata is valid
//   ls_req         load/store request
//   ls_we          1 = store, 0 = load
//   ls_addr        load/store byte address
//   ls_size        00 byte, 01 half, 10 word, 11 illegal
//   ls_unsigned    load: 1 = zero-extend, 0 = sign-extend
//   ls_wdata       store data, right-aligned
//   ls_rdata       extended load data (0 for stores and rejected accesses)
//   ls_valid       one-cycle pulse, LS response
//   ls_misaligned  qualifies ls_valid: the access was rejected
// -----------------------------------------------------------------------------
module multi_port_ram #(
    parameter int DEPTH     = 32,
    parameter int ADDR_W    = 32,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_valid,
    output logic              ls_misaligned
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Alignment rule: byte anywhere, half on even, word on multiple of 4.
    function automatic logic size_ok(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~lo[0];
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by an access of the given size at lane offset lo.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Shift the selected lanes down and extend them to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    logic [31:0]      mem_r [DEPTH];
    state_t           state_r;
    state_t           state_next_s;
    logic [IDX_W-1:0] init_cnt_r;
    logic             ready_r;
    logic [31:0]      if_rdata_r;
    logic             if_valid_r;
    logic [31:0]      ls_rdata_r;
    logic             ls_valid_r;
    logic             ls_misaligned_r;

    logic [IDX_W-1:0] if_idx_s;
    logic [IDX_W-1:0] ls_idx_s;
    logic [1:0]       ls_lo_s;
    logic             ls_ok_s;
    logic             ls_acc_s;
    logic             if_acc_s;
    logic             st_we_s;
    logic             init_we_s;
    logic [3:0]       be_s;
    logic [31:0]      lanes_s;
    logic [31:0]      ls_word_s;
    logic [31:0]      merged_s;
    logic [31:0]      if_word_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [31:0]      wr_data_s;
    logic             wr_en_s;
    logic             unused_addr_s;

    assign if_idx_s      = if_addr[IDX_W+1:2];
    assign ls_idx_s      = ls_addr[IDX_W+1:2];
    assign ls_lo_s       = ls_addr[1:0];
    assign ls_ok_s       = size_ok(ls_size, ls_lo_s);
    assign ls_acc_s      = ls_req & ready_r;
    assign if_acc_s      = if_req & ready_r;
    assign st_we_s       = ls_acc_s & ls_we & ls_ok_s;
    assign init_we_s     = (state_r == ST_INIT) && (INIT_ZERO != 1'b0);
    assign be_s          = byte_en(ls_size, ls_lo_s);
    assign ls_word_s     = mem_r[ls_idx_s];
    // Upper address bits alias; fetch lane bits are don't-care.
    assign unused_addr_s = ^{if_addr[ADDR_W-1:IDX_W+2], if_addr[1:0], ls_addr[ADDR_W-1:IDX_W+2]};

    // Replicate store data over every lane and merge the enabled lanes into the stored word.
    always_comb begin
        lanes_s  = ls_wdata;
        merged_s = ls_word_s;
        case (ls_size)
            2'b00:   lanes_s = {4{ls_wdata[7:0]}};
            2'b01:   lanes_s = {2{ls_wdata[15:0]}};
            default: lanes_s = ls_wdata;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
                merged_s[8*i +: 8] = lanes_s[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = ls_word_s[8*i +: 8];
            end
        end
    end

    // Fetch is write-first: a same-cycle store to the same word is forwarded.
    always_comb begin
        if_word_s = mem_r[if_idx_s];
        if (st_we_s && (ls_idx_s == if_idx_s)) begin
            if_word_s = merged_s;
        end else begin
            if_word_s = mem_r[if_idx_s];
        end
    end

    // Single array write port shared by the zero-fill sequencer and LS stores.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = ls_idx_s;
        wr_data_s = merged_s;
        if (init_we_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = init_cnt_r;
            wr_data_s = 32'h0000_0000;
        end else if (st_we_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = ls_idx_s;
            wr_data_s = merged_s;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Storage array; contents are defined by the fill sequencer, not by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Next-state logic: INIT runs once per reset, RUN is left only by reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INIT: begin
                if ((INIT_ZERO == 1'b0) || (init_cnt_r == IDX_W'(DEPTH - 1))) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_INIT;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_INIT;
        endcase
    end

    // State register, fill counter and registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_INIT;
            init_cnt_r <= {IDX_W{1'b0}};
            ready_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_RUN);
            if (state_r == ST_INIT) begin
                init_cnt_r <= init_cnt_r + 1'b1;
            end else begin
                init_cnt_r <= init_cnt_r;
            end
        end
    end

    // Registered fetch response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata_r <= 32'h0000_0000;
            if_valid_r <= 1'b0;
        end else begin
            if_valid_r <= if_acc_s;
            if (if_acc_s) begin
                if_rdata_r <= if_word_s;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
        end
    end

    // Registered load/store response; stores and rejected accesses return 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ls_rdata_r      <= 32'h0000_0000;
            ls_valid_r      <= 1'b0;
            ls_misaligned_r <= 1'b0;
        end else begin
            ls_valid_r <= ls_acc_s;
            if (ls_acc_s) begin
                ls_misaligned_r <= ~ls_ok_s;
                if (ls_ok_s && !ls_we) begin
                    ls_rdata_r <= load_extend(ls_word_s, ls_size, ls_lo_s, ls_unsigned);
                end else begin
                    ls_rdata_r <= 32'h0000_0000;
                end
            end else begin
                ls_misaligned_r <= 1'b0;
                ls_rdata_r      <= ls_rdata_r;
            end
        end
    end

    assign ready         = ready_r;
    assign if_rdata      = if_rdata_r;
    assign if_valid      = if_valid_r;
    assign ls_rdata      = ls_rdata_r;
    assign ls_valid      = ls_valid_r;
    assign ls_misaligned = ls_misaligned_r;

endmodule
